// File: rtl/ula_pkg.sv
// Shared definitions for the ula_pipe ALU: opcode encodings, control FSM states,
// and the result returned for the reserved opcodes 1100-1111.
package ula_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_NOT  = 4'b0011;
  localparam logic [3:0] OP_ANDN = 4'b0100;
  localparam logic [3:0] OP_ORN  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SHL  = 4'b1000;
  localparam logic [3:0] OP_SHR  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_EQ   = 4'b1011;

  // Reserved opcodes complete in one cycle with every result bit and carry at these values.
  localparam logic RSV_FILL  = 1'b0;
  localparam logic RSV_CARRY = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/ula_mul_seq.sv
// Iterative shift-add multiplier: the first partial product is formed at start,
// each later cycle adds one more bit, and done pulses once the product is complete.
module ula_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic               busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc    <= B[0] ? {{WIDTH{1'b0}}, A} : '0;
        mcand  <= {{WIDTH{1'b0}}, A} << 1;
        mplier <= B >> 1;
        cnt    <= CNT_W'(1);
        busy   <= 1'b1;
      end else if (busy) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        // Bit WIDTH-1 is being added now, so the product is final after this edge.
        if (cnt == CNT_W'(WIDTH - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign product = acc;

endmodule

// File: rtl/ula_pipe.sv
// Handshaked ALU with a one-register result stage and an iterative multiply.
// Define ULA_SAT_EN to saturate add/sub/multiply results instead of wrapping.
module ula_pipe
  import ula_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       seletor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] resultado,
  output logic             carry_out,
  output logic             zero
);

`ifdef ULA_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  state_t             state, state_nxt;
  logic               accept, mul_start, mul_done;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH:0]     alu_out;
  logic [WIDTH-1:0]   mul_res;
  logic               mul_carry;

  function automatic logic [WIDTH-1:0] sat_to(input logic [WIDTH-1:0] r,
                                              input logic hit,
                                              input logic [WIDTH-1:0] lim);
    return (SAT_EN && hit) ? lim : r;
  endfunction

  // Returns {carry, result} for every opcode that completes in a single cycle.
  function automatic logic [WIDTH:0] alu(input logic [3:0] op,
                                         input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b);
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] r;
    logic             c;
    sum = '0;
    r   = '0;
    c   = 1'b0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_ADD: begin
        sum = {1'b0, a} + {1'b0, b};
        c   = sum[WIDTH];
        r   = sat_to(sum[WIDTH-1:0], c, '1);
      end
      OP_NOT:  r = ~a;
      OP_ANDN: r = a & ~b;
      OP_ORN:  r = a | ~b;
      OP_SUB: begin
        c = (a >= b);
        r = sat_to(a - b, !c, '0);
      end
      OP_SLT:  r = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SHL: begin
        r = {a[WIDTH-2:0], 1'b0};
        c = a[WIDTH-1];
      end
      OP_SHR: begin
        r = {1'b0, a[WIDTH-1:1]};
        c = a[0];
      end
      OP_EQ:   r = {{(WIDTH-1){1'b0}}, (a == b)};
      default: begin
        r = {WIDTH{RSV_FILL}};
        c = RSV_CARRY;
      end
    endcase
    return {c, r};
  endfunction

  assign in_ready  = !rst && (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (seletor == OP_MUL);

  assign alu_out   = alu(seletor, A, B);
  assign mul_carry = |product[2*WIDTH-1:WIDTH];
  assign mul_res   = sat_to(product[WIDTH-1:0], mul_carry, '1);

  ula_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .A       (A),
    .B       (B),
    .done    (mul_done),
    .product (product)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (mul_start)                   state_nxt = ST_MUL;
        else if (out_valid && !out_ready) state_nxt = ST_HOLD;
      end
      ST_MUL:  if (mul_done)  state_nxt = ST_IDLE;
      ST_HOLD: if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Result stage: a new result may overwrite one being consumed on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      resultado <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
    end else if (accept && !mul_start) begin
      out_valid <= 1'b1;
      resultado <= alu_out[WIDTH-1:0];
      carry_out <= alu_out[WIDTH];
      zero      <= (alu_out[WIDTH-1:0] == '0);
    end else if ((state == ST_MUL) && mul_done) begin
      out_valid <= 1'b1;
      resultado <= mul_res;
      carry_out <= mul_carry;
      zero      <= (mul_res == '0);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ula_pipe.sv
// Bench for ula_pipe (WIDTH=8): directed vector table, multiply/backpressure/reset
// sequences, and randomized traffic scored against an arithmetic reference model.
module tb_ula_pipe;
  import ula_pkg::*;

`ifdef ULA_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk, rst, in_valid, in_ready, out_valid, out_ready, carry_out, zero;
  logic [7:0] A, B, resultado;
  logic [3:0] seletor;

  ula_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .seletor   (seletor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .resultado (resultado),
    .carry_out (carry_out),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic       c;
    logic       z;
  } vec_t;

  vec_t       vt[$];
  logic [9:0] exp_q[$];
  int         n_vec, n_err, n_acc, n_cons;
  bit         sb_on;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference behaviour from plain integer arithmetic; returns {result, carry, zero}.
  function automatic logic [9:0] model(input logic [3:0] op, input logic [7:0] a8,
                                       input logic [7:0] b8);
    int a, b, r, c;
    a = int'(a8);
    b = int'(b8);
    r = 0;
    c = 0;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  begin r = (a + b) % 256; c = (a + b >= 256); if (SAT && c != 0) r = 255; end
      4'd3:  r = 255 - a;
      4'd4:  r = a & (255 - b);
      4'd5:  r = a | (255 - b);
      4'd6:  begin r = (a - b + 256) % 256; c = (a >= b); if (SAT && a < b) r = 0; end
      4'd7:  r = (a < b) ? 1 : 0;
      4'd8:  begin r = (a * 2) % 256; c = (a >= 128); end
      4'd9:  begin r = a / 2; c = a % 2; end
      4'd10: begin r = (a * b) % 256; c = (a * b >= 256); if (SAT && c != 0) r = 255; end
      4'd11: r = (a == b) ? 1 : 0;
      default: r = 0;
    endcase
    return {8'(r), c[0], (r == 0)};
  endfunction

  // Scoreboard: observes handshakes half a cycle before the edge that performs them.
  always @(negedge clk) begin
    #1;
    if (sb_on && !rst) begin
      if (out_valid && out_ready) begin
        n_cons++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_underflow: unexpected result 0x%0h at %0t", resultado, $time);
        end else begin
          check("sb_result", {22'd0, resultado, carry_out, zero}, {22'd0, exp_q.pop_front()});
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(seletor, A, B));
        n_acc++;
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      output int w);
    int start;
    seletor  = op;
    A        = a;
    B        = b;
    in_valid = 1'b1;
    start    = n_acc;
    w        = 0;
    do begin
      @(negedge clk);
      w++;
    end while (n_acc == start && w < 40);
    if (n_acc == start) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: op %0h not accepted after %0d cycles", op, w);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, w, cnt;
    bit prev_mul;
    n_vec = 0; n_err = 0; n_acc = 0; n_cons = 0; sb_on = 1'b0;

    vt.push_back('{OP_ADD,  8'hF0, 8'h20, SAT ? 8'hFF : 8'h10, 1'b1, 1'b0});
    vt.push_back('{OP_SUB,  8'h05, 8'h07, SAT ? 8'h00 : 8'hFE, 1'b0, SAT});
    vt.push_back('{OP_SUB,  8'h07, 8'h05, 8'h02, 1'b1, 1'b0});
    vt.push_back('{OP_AND,  8'h0F, 8'h3C, 8'h0C, 1'b0, 1'b0});
    vt.push_back('{OP_OR,   8'h0F, 8'h3C, 8'h3F, 1'b0, 1'b0});
    vt.push_back('{OP_NOT,  8'h00, 8'h12, 8'hFF, 1'b0, 1'b0});
    vt.push_back('{OP_ANDN, 8'hF0, 8'h3C, 8'hC0, 1'b0, 1'b0});
    vt.push_back('{OP_ORN,  8'h00, 8'hFF, 8'h00, 1'b0, 1'b1});
    vt.push_back('{OP_SLT,  8'h03, 8'h04, 8'h01, 1'b0, 1'b0});
    vt.push_back('{OP_SLT,  8'h04, 8'h04, 8'h00, 1'b0, 1'b1});
    vt.push_back('{OP_SHL,  8'h81, 8'h00, 8'h02, 1'b1, 1'b0});
    vt.push_back('{OP_SHR,  8'h81, 8'h00, 8'h40, 1'b1, 1'b0});
    vt.push_back('{OP_EQ,   8'h55, 8'h55, 8'h01, 1'b0, 1'b0});
    vt.push_back('{4'hC,    8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1});
    vt.push_back('{4'hF,    8'h80, 8'h80, 8'h00, 1'b0, 1'b1});
    vt.push_back('{OP_ADD,  8'hFF, 8'h01, SAT ? 8'hFF : 8'h00, 1'b1, !SAT});

    // Reset with a request pending
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; A = 8'hAA; B = 8'h55; seletor = OP_ADD;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_outputs", {resultado, carry_out, zero}, 0);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("ready_after_rst", in_ready, 1);

    // Directed table, back to back
    foreach (vt[i]) begin
      seletor = vt[i].op; A = vt[i].a; B = vt[i].b; in_valid = 1'b1;
      @(negedge clk);
      check($sformatf("vec%0d_op%0h", i, vt[i].op), {out_valid, resultado, carry_out, zero},
            {1'b1, vt[i].r, vt[i].c, vt[i].z});
    end

    // Multiply latency, in_ready low throughout, operands changed after accept
    seletor = OP_MUL; A = 8'h13; B = 8'h11; in_valid = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        in_valid = 1'b0; A = 8'hFF; B = 8'hFF; seletor = OP_ADD;
      end
      if (!out_valid) check("mul_busy_ready", in_ready, 0);
    end while (!out_valid && lat < 40);
    check("mul_latency", lat, 9);
    check("mul_result", {resultado, carry_out, zero}, {SAT ? 8'hFF : 8'h43, 1'b1, 1'b0});
    @(negedge clk);
    check("consume_clears", out_valid, 0);
    check("consume_holds", resultado, SAT ? 8'hFF : 8'h43);

    // Reset in the third multiply cycle aborts it
    seletor = OP_MUL; A = 8'h13; B = 8'h11; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midmul_rst_ready", in_ready, 0);
    check("midmul_rst_outputs", {out_valid, resultado, carry_out, zero}, 0);
    rst = 1'b0;
    #1;
    check("midmul_ready_after", in_ready, 1);
    cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("midmul_no_result", cnt, 0);

    // Backpressure: held result, then consume with a new request
    exp_q.delete(); n_acc = 0; n_cons = 0; sb_on = 1'b1;
    seletor = OP_AND; A = 8'h0F; B = 8'h3C; in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) in_valid = 1'b0;
      check("hold_stable", {out_valid, in_ready, resultado}, {1'b1, 1'b0, 8'h0C});
    end
    out_ready = 1'b1;
    send(OP_NOT, 8'h00, 8'h00, w);
    check("hold_next_result", {out_valid, resultado, carry_out}, {1'b1, 8'hFF, 1'b0});

    // All sixteen opcodes in order, one accept per cycle when no multiply precedes
    prev_mul = 1'b1;
    for (int i = 0; i < 48; i++) begin
      send(4'(i % 16), 8'($urandom), 8'($urandom), w);
      if (!prev_mul) check("b2b_rate", w, 1);
      prev_mul = ((i % 16) == 10);
    end

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom % 2) == 0;
      seletor   = 4'($urandom);
      A         = 8'($urandom);
      B         = ($urandom % 8 == 0) ? A : 8'($urandom);
      out_ready = ($urandom % 4) != 0;
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    w = 0;
    while ((exp_q.size() != 0 || out_valid) && w < 60) begin
      @(negedge clk);
      w++;
    end
    check("drain_empty", exp_q.size(), 0);
    check("drain_count", n_cons, n_acc);
    sb_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ula_pipe.md
ULA_PIPE -- requirements
Module: ula_pipe

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  operation request present.
REQ-005 SHALL have port: in_ready  output  1  request accepted when in_valid and in_ready both high at an edge.
REQ-006 SHALL have ports: A, B  input  WIDTH  operands.
REQ-007 SHALL have port: seletor  input  4  operation code.
REQ-008 SHALL have port: out_valid  output  1  result registers hold an unconsumed result.
REQ-009 SHALL have port: out_ready  input  1  consumer takes result when out_valid and out_ready both high.
REQ-010 SHALL have ports: resultado  output  WIDTH; carry_out  output  1; zero  output  1 (resultado == 0).

Function
REQ-011 SHALL implement opcodes (unsigned): 0000 A&B; 0001 A|B; 0010 A+B, carry_out=bit WIDTH; 0011 ~A; 0100 A&~B; 0101 A|~B (bitwise); 0110 A-B, carry_out=1 iff A>=B; 0111 resultado=1 iff A<B; 1000 A<<1, carry_out=A[MSB]; 1001 A>>1, carry_out=A[0]; 1010 low WIDTH bits of A*B, carry_out=1 iff high half nonzero; 1011 resultado=1 iff A==B.
REQ-012 Opcodes 1100-1111 SHALL be accepted as single-cycle ops giving resultado=0, carry_out=0.
REQ-013 carry_out SHALL be 0 for all opcodes not listed with a carry rule.
REQ-014 SHALL use a 3-state FSM: IDLE, MUL, HOLD.
REQ-015 in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready).
REQ-016 Single-cycle op accepted at edge k: result registered at edge k, out_valid=1 from cycle k+1 (latency 1).
REQ-017 Opcode 1010 accepted at edge k: IDLE->MUL, iterative shift-add, one bit per cycle; result registered and out_valid=1 after edge k+WIDTH; MUL->IDLE.
REQ-018 in_ready SHALL be 0 throughout MUL.
REQ-019 out_valid high and out_ready low: IDLE->HOLD; resultado/carry_out/zero SHALL remain stable until consumed; HOLD->IDLE on out_ready.
REQ-020 Simultaneous consume and new accept in the same cycle SHALL be lossless: new single-cycle result replaces old, out_valid stays 1.
REQ-021 Consume with no new accept SHALL clear out_valid at that edge; resultado holds last value.
REQ-022 Operands and seletor SHALL be sampled only at accept; later input changes SHALL not affect an in-flight multiply.

Reset
REQ-023 rst high at an edge SHALL force state=IDLE, out_valid=0, resultado=0, carry_out=0, zero=0, multiplier registers cleared.
REQ-024 rst during MUL or HOLD SHALL abort the operation; no result is ever presented for it.
REQ-025 in_valid during rst SHALL be ignored; in_ready SHALL be 0 while rst high.

Configuration
REQ-026 Macro ULA_SAT_EN defined: opcode 0010 SHALL saturate resultado to all-ones on carry, opcode 0110 SHALL saturate to 0 when A<B, opcode 1010 to all-ones when high half nonzero; carry_out rules unchanged.
REQ-027 ULA_SAT_EN undefined: wrap-around (modulo 2^WIDTH) results for all arithmetic.

Structure
REQ-028 Package ula_pkg SHALL hold opcode localparams, FSM state typedef, and the reserved-opcode default.
REQ-029 Iterative multiplier SHALL be sub-module ula_mul_seq (start, done, A, B, product of 2*WIDTH bits).

Verification (WIDTH=8)
REQ-030 Add: A=0xF0, B=0x20, 0010, out_ready=1 -> next cycle resultado=0x10, carry_out=1, zero=0; with ULA_SAT_EN resultado=0xFF.
REQ-031 Sub: A=0x05, B=0x07, 0110 -> resultado=0xFE, carry_out=0 (ULA_SAT_EN: 0x00, zero=1); A=0x07,B=0x05 -> 0x02, carry_out=1.
REQ-032 Multiply: A=0x13, B=0x11, 1010 -> in_ready=0 for 8 cycles, out_valid after edge k+8, resultado=0x43, carry_out=1.
REQ-033 Backpressure: out_ready=0 for 5 cycles after A=0x0F&B=0x3C -> resultado=0x0C held stable, in_ready=0; out_ready=1 with new op 0011 A=0x00 -> next resultado=0xFF, no result lost.
REQ-034 Reset mid-multiply: rst at cycle 3 of MUL -> out_valid=0, all outputs 0, in_ready=1 cycle after rst drops.
REQ-035 Back-to-back single-cycle ops with out_ready=1 every cycle -> one result per cycle, in order, all 16 opcodes checked against a reference model.
